// File: rtl/layer_4_channel_packer.sv
// Packs NUM_CH serial channel samples into one wide pixel word, framing IMG_SIZE*IMG_SIZE pixels per start.
// Optional raster position outputs (row_out/col_out) are enabled by defining LAYER_4_PACKER_POS_EN.
module layer_4_channel_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 32,
   parameter int unsigned IMG_SIZE   = 104
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         start,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
   output logic                         valid_out,
   output logic                         frame_done,
`ifdef LAYER_4_PACKER_POS_EN
   output logic [$clog2(IMG_SIZE)-1:0]  row_out,
   output logic [$clog2(IMG_SIZE)-1:0]  col_out,
`endif
   output logic                         busy
);

   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PIX_W    = $clog2(IMG_SIZE * IMG_SIZE);
   localparam int unsigned PIX_LAST = IMG_SIZE * IMG_SIZE - 1;
   localparam int unsigned STG_W    = DATA_WIDTH * (NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

   state_t             state;
   state_t             next_state;
   logic [CH_W-1:0]    ch_cnt;
   logic [PIX_W-1:0]   pix_cnt;
   logic [STG_W-1:0]   staging;
   logic               accept;
   logic               pixel_done;
   logic               frame_last;

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next state and accept decode
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      pixel_done = 1'b0;
      frame_last = 1'b0;
      case (state)
         IDLE: if (start) next_state = PACK;
         PACK: begin
            accept     = in_valid && in_ready;
            pixel_done = accept && (ch_cnt == CH_W'(NUM_CH - 1));
            frame_last = pixel_done && (pix_cnt == PIX_W'(PIX_LAST));
            if (frame_last) next_state = DONE;
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Channel staging, pixel emission and status flags
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ch_cnt     <= '0;
         pix_cnt    <= '0;
         staging    <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         valid_out  <= pixel_done;
         frame_done <= (next_state == DONE);
         busy       <= (next_state != IDLE);
         in_ready   <= (next_state == PACK);
         if (state == IDLE && start) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
         end else if (accept) begin
            if (pixel_done) begin
               // Last channel bypasses staging so the pixel appears one cycle after its final word
               ch_cnt   <= '0;
               data_out <= {in_data, staging};
               pix_cnt  <= frame_last ? '0 : pix_cnt + PIX_W'(1);
            end else begin
               for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
                  if (ch_cnt == CH_W'(k)) staging[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
               end
               ch_cnt <= ch_cnt + CH_W'(1);
            end
         end
      end
   end

`ifdef LAYER_4_PACKER_POS_EN
   localparam int unsigned POS_W = $clog2(IMG_SIZE);

   logic [POS_W-1:0] row_cnt;
   logic [POS_W-1:0] col_cnt;

   // Raster position of the next pixel, published with each emitted pixel
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         row_cnt <= '0;
         col_cnt <= '0;
         row_out <= '0;
         col_out <= '0;
      end else if (state == IDLE && start) begin
         row_cnt <= '0;
         col_cnt <= '0;
      end else if (pixel_done) begin
         row_out <= row_cnt;
         col_out <= col_cnt;
         if (col_cnt == POS_W'(IMG_SIZE - 1)) begin
            col_cnt <= '0;
            row_cnt <= (row_cnt == POS_W'(IMG_SIZE - 1)) ? '0 : row_cnt + POS_W'(1);
         end else begin
            col_cnt <= col_cnt + POS_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_layer_4_channel_packer.sv
// Directed bench for layer_4_channel_packer with a 4x4 frame of 32-channel pixels.
module tb_layer_4_channel_packer;

   localparam int unsigned DW = 32;
   localparam int unsigned NC = 32;
   localparam int unsigned IS = 4;

   logic             Clk;
   logic             Rst;
   logic             start;
   logic [DW-1:0]    in_data;
   logic             in_valid;
   logic             in_ready;
   logic [DW*NC-1:0] data_out;
   logic             valid_out;
   logic             frame_done;
   logic             busy;
`ifdef LAYER_4_PACKER_POS_EN
   logic [1:0]       row_out;
   logic [1:0]       col_out;
`endif

   layer_4_channel_packer #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_SIZE(IS)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .valid_out(valid_out),
      .frame_done(frame_done),
`ifdef LAYER_4_PACKER_POS_EN
      .row_out(row_out), .col_out(col_out),
`endif
      .busy(busy)
   );

   typedef struct {
      logic [31:0] base;
      int          stall_at;
      int          stall_len;
      bit          mid_start;
      int          exp_cyc;
      logic [31:0] exp_s0;
      logic [31:0] exp_s31;
      int          row;
      int          col;
   } vec_t;

   vec_t tab[16];
   vec_t nv;
   int   total = 0;
   int   bad   = 0;
   int   vcnt  = 0;
   int   fcnt  = 0;
   int   cyc   = 0;
   int   vsave;
   logic prev_v = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Pulse counters and back-to-back valid_out check
   always @(negedge Clk) begin
      if (Rst) begin
         if (valid_out) begin
            vcnt++;
            total++;
            if (prev_v) begin
               bad++;
               $display("FAIL valid_back_to_back act=1 exp=0 at cyc=%0d", cyc);
            end
         end
         if (frame_done) fcnt++;
         prev_v = valid_out;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic check_pix(input string name, input logic [31:0] base);
      logic [DW*NC-1:0] e;
      int first;
      for (int k = 0; k < NC; k++) e[k*DW +: DW] = base + 32'(k);
      total++;
      if (data_out !== e) begin
         bad++;
         first = -1;
         for (int k = NC - 1; k >= 0; k--) if (data_out[k*DW +: DW] !== e[k*DW +: DW]) first = k;
         $display("FAIL %s slot=%0d act=%0h exp=%0h", name, first,
                  data_out[first*DW +: DW], e[first*DW +: DW]);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_pixel(input vec_t v, input int idx);
      int n;
      int cyc0;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check($sformatf("ready_p%0d", idx), 64'(in_ready), 64'd1);
      cyc0 = cyc;
      for (int k = 0; k < NC; k++) begin
         in_valid = 1'b1;
         in_data  = v.base + 32'(k);
         start    = v.mid_start && (k == 5);
         tick();
         start = 1'b0;
         if (k == v.stall_at) begin
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            repeat (v.stall_len) tick();
         end
      end
      in_valid = 1'b0;
      check($sformatf("valid_p%0d", idx), 64'(valid_out), 64'd1);
      check($sformatf("latency_p%0d", idx), 64'(cyc - cyc0), 64'(v.exp_cyc));
      check($sformatf("slot0_p%0d", idx), 64'(data_out[31:0]), 64'(v.exp_s0));
      check($sformatf("slot31_p%0d", idx), 64'(data_out[DW*NC-1 -: DW]), 64'(v.exp_s31));
      check_pix($sformatf("pixel_p%0d", idx), v.base);
`ifdef LAYER_4_PACKER_POS_EN
      check($sformatf("row_p%0d", idx), 64'(row_out), 64'(v.row));
      check($sformatf("col_p%0d", idx), 64'(col_out), 64'(v.col));
`endif
   endtask

   initial begin
      tab[0] = '{32'h3F800000, -1, 0, 1'b0, 32, 32'h3F800000, 32'h3F80001F, 0, 0};
      tab[1] = '{32'h3F800000, 10, 5, 1'b0, 37, 32'h3F800000, 32'h3F80001F, 0, 1};
      tab[2] = '{32'h40000000, -1, 0, 1'b0, 32, 32'h40000000, 32'h4000001F, 0, 2};
      tab[3] = '{32'hC0000100, -1, 0, 1'b1, 32, 32'hC0000100, 32'hC000011F, 0, 3};
      tab[4] = '{32'h00000000, -1, 0, 1'b0, 32, 32'h00000000, 32'h0000001F, 1, 0};
      tab[5] = '{32'hFFFFFFE0, -1, 0, 1'b0, 32, 32'hFFFFFFE0, 32'hFFFFFFFF, 1, 1};
      tab[6] = '{32'h12345600,  0, 2, 1'b0, 34, 32'h12345600, 32'h1234561F, 1, 2};
      tab[7] = '{32'h7F7FFF00, -1, 0, 1'b0, 32, 32'h7F7FFF00, 32'h7F7FFF1F, 1, 3};
      tab[8] = '{32'hA5A5A500, -1, 0, 1'b0, 32, 32'hA5A5A500, 32'hA5A5A51F, 2, 0};
      tab[9] = '{32'h5A5A5A00, 30, 1, 1'b0, 33, 32'h5A5A5A00, 32'h5A5A5A1F, 2, 1};
      for (int i = 10; i < 16; i++)
         tab[i] = '{32'h41000000 + (32'(i) << 8), -1, 0, 1'b0, 32,
                    32'h41000000 + (32'(i) << 8), 32'h4100001F + (32'(i) << 8), i / 4, i % 4};

      Rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      #2 Rst = 1'b0;
      #1;
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_data", 64'(data_out == '0), 64'd1);
      repeat (3) tick();
      Rst = 1'b1;

      // Words offered while idle must be dropped
      in_valid = 1'b1; in_data = 32'h12345678;
      repeat (3) tick();
      check("idle_ready", 64'(in_ready), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_vcnt", 64'(vcnt), 64'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("pack_busy", 64'(busy), 64'd1);
      check("pack_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 16; i++) begin
         send_pixel(tab[i], i);
         if (i < 15) check($sformatf("no_done_p%0d", i), 64'(frame_done), 64'd0);
      end
      check("done_pulse", 64'(frame_done), 64'd1);
      check("done_busy", 64'(busy), 64'd1);
      check("done_ready", 64'(in_ready), 64'd0);
      tick();
      check("post_done", 64'(frame_done), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
      check("post_ready", 64'(in_ready), 64'd0);
      check("frame_vcnt", 64'(vcnt), 64'd16);
      check("frame_fcnt", 64'(fcnt), 64'd1);
      repeat (3) tick();
      check("idle_ready2", 64'(in_ready), 64'd0);
      check_pix("hold_last", tab[15].base);

      // Reset in the middle of pixel 2
      start = 1'b1;
      tick();
      start = 1'b0;
      send_pixel(tab[0], 100);
      send_pixel(tab[1], 101);
      for (int k = 0; k <= 20; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h3F000000 + 32'(k);
         tick();
      end
      vsave = vcnt;
      #3 Rst = 1'b0;
      #1;
      check("arst_valid", 64'(valid_out), 64'd0);
      check("arst_done", 64'(frame_done), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(in_ready), 64'd0);
      check("arst_data", 64'(data_out == '0), 64'd1);
      repeat (2) tick();
      Rst = 1'b1;
      in_data = 32'hBAD0BAD0;
      repeat (3) tick();
      check("arst_vcnt", 64'(vcnt), 64'(vsave));
      check("arst_fcnt", 64'(fcnt), 64'd1);
      check("arst_idle_ready", 64'(in_ready), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      nv = '{32'h40490FDB, -1, 0, 1'b0, 32, 32'h40490FDB, 32'h40490FFA, 0, 0};
      send_pixel(nv, 200);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
